register_file: RTL and testbench

- Architectural register file with rename-tag tracking. Sits directly downstream of the reorder buffer's commit port and is read by the dispatcher.
- Holds 32 committed values plus, per register, the ROB tag of the youngest in-flight writer.
- Supplies operands (value or pending tag) to dispatch. Retires ROB commits into architectural state.
- Drops all rename tags on a misprediction flush.

---
 rtl/register_file_pkg.sv | 46 ++++
 rtl/register_file_if.sv | 37 +++
 rtl/register_file.sv | 59 +++++
 tb/tb_register_file.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants, types and the operand-read helper for the architectural register file.
package register_file_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_NUM   = 32;
    localparam int unsigned TAG_WIDTH = 5;
    localparam int unsigned REG_IDX_W = $clog2(REG_NUM);

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam tag_t     NO_TAG = '0;
    localparam reg_idx_t X0     = '0;

    typedef struct packed {
        word_t value;
        tag_t  tag;
    } operand_t;

    // An operand whose pending writer retires this very cycle is returned as ready with the
    // commit result, so dispatch never waits on a value that is already on the commit bus.
    function automatic operand_t read_operand(
        input reg_idx_t idx,
        input word_t    stored_val,
        input tag_t     stored_dep,
        input logic     commit_valid,
        input reg_idx_t commit_rd,
        input word_t    commit_res,
        input tag_t     commit_dep
    );
        operand_t op;
        op.value = stored_val;
        op.tag   = stored_dep;
        if (idx == X0) begin
            op.value = '0;
            op.tag   = NO_TAG;
        end else if (commit_valid && commit_rd == idx &&
                     stored_dep != NO_TAG && stored_dep == commit_dep) begin
            op.value = commit_res;
            op.tag   = NO_TAG;
        end
        return op;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Commit, rename and operand-read bus between ROB/dispatcher (master) and register file (slave).
interface register_file_if;
    import register_file_pkg::*;

    logic     rdy;
    logic     flush;
    logic     commit_valid;
    reg_idx_t commit_rd;
    word_t    commit_res;
    tag_t     commit_dependency;
    logic     rename_valid;
    reg_idx_t rename_rd;
    tag_t     rename_tag;
    reg_idx_t rs1_idx;
    reg_idx_t rs2_idx;
    word_t    rs1_value;
    tag_t     rs1_tag;
    word_t    rs2_value;
    tag_t     rs2_tag;

    modport master (
        output rdy, flush,
        output commit_valid, commit_rd, commit_res, commit_dependency,
        output rename_valid, rename_rd, rename_tag,
        output rs1_idx, rs2_idx,
        input  rs1_value, rs1_tag, rs2_value, rs2_tag
    );

    modport slave (
        input  rdy, flush,
        input  commit_valid, commit_rd, commit_res, commit_dependency,
        input  rename_valid, rename_rd, rename_tag,
        input  rs1_idx, rs2_idx,
        output rs1_value, rs1_tag, rs2_value, rs2_tag
    );

endinterface

// File: rtl/register_file.sv
// Architectural register file: committed values plus youngest in-flight writer tag per register.
module register_file
    import register_file_pkg::*;
(
    input logic            clk,
    input logic            rst,
    register_file_if.slave rf
);

    word_t val [REG_NUM];
    tag_t  dep [REG_NUM];

    logic commit_we;
    logic rename_we;

    assign commit_we = rf.commit_valid && rf.commit_rd != X0;
    assign rename_we = rf.rename_valid && rf.rename_rd != X0 && !rf.flush;

    // Later assignments win: flush clear, then commit clear, then a rename tag overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val[reg_idx_t'(i)] <= '0;
                dep[reg_idx_t'(i)] <= NO_TAG;
            end
        end else if (rf.rdy) begin
            if (rf.flush) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    dep[reg_idx_t'(i)] <= NO_TAG;
                end
            end
            if (commit_we) begin
                val[rf.commit_rd] <= rf.commit_res;
                if (dep[rf.commit_rd] == rf.commit_dependency) begin
                    dep[rf.commit_rd] <= NO_TAG;
                end
            end
            if (rename_we) begin
                dep[rf.rename_rd] <= rf.rename_tag;
            end
        end
    end

    operand_t op1;
    operand_t op2;

    always_comb begin
        op1 = read_operand(rf.rs1_idx, val[rf.rs1_idx], dep[rf.rs1_idx],
                           rf.commit_valid, rf.commit_rd, rf.commit_res, rf.commit_dependency);
        op2 = read_operand(rf.rs2_idx, val[rf.rs2_idx], dep[rf.rs2_idx],
                           rf.commit_valid, rf.commit_rd, rf.commit_res, rf.commit_dependency);
    end

    assign rf.rs1_value = op1.value;
    assign rf.rs1_tag   = op1.tag;
    assign rf.rs2_value = op2.value;
    assign rf.rs2_tag   = op2.tag;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios then randomized traffic vs. an array model.
module tb_register_file;
    import register_file_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_if rf ();

    register_file dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mval [32];
    logic [4:0]  mdep [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic r_dy, input logic fl,
                          input logic cv, input logic [4:0] crd, input logic [31:0] cres,
                          input logic [4:0] cdep,
                          input logic rv, input logic [4:0] rrd, input logic [4:0] rtag,
                          input logic [4:0] i1, input logic [4:0] i2);
        rf.rdy               = r_dy;
        rf.flush             = fl;
        rf.commit_valid      = cv;
        rf.commit_rd         = crd;
        rf.commit_res        = cres;
        rf.commit_dependency = cdep;
        rf.rename_valid      = rv;
        rf.rename_rd         = rrd;
        rf.rename_tag        = rtag;
        rf.rs1_idx           = i1;
        rf.rs2_idx           = i2;
        #1;
    endtask

    task automatic set_idle(input logic [4:0] i1, input logic [4:0] i2);
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 5'd0, 5'd0, i1, i2);
    endtask

    // Reference read: a register retiring now reads as its commit result, otherwise as stored.
    function automatic logic [31:0] exp_val(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (rf.commit_valid && rf.commit_rd == idx && mdep[idx] != 0 &&
            mdep[idx] == rf.commit_dependency) return rf.commit_res;
        return mval[idx];
    endfunction

    function automatic logic [31:0] exp_tag(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (rf.commit_valid && rf.commit_rd == idx && mdep[idx] != 0 &&
            mdep[idx] == rf.commit_dependency) return 32'd0;
        return {27'd0, mdep[idx]};
    endfunction

    task automatic update_model();
        logic [4:0] nd [32];
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mval[i] = 32'd0;
                mdep[i] = 5'd0;
            end
        end else if (rf.rdy) begin
            nd = mdep;
            if (rf.flush) for (int i = 0; i < 32; i++) nd[i] = 5'd0;
            if (rf.commit_valid && rf.commit_rd != 0) begin
                mval[rf.commit_rd] = rf.commit_res;
                if (mdep[rf.commit_rd] == rf.commit_dependency) nd[rf.commit_rd] = 5'd0;
            end
            if (!rf.flush && rf.rename_valid && rf.rename_rd != 0) nd[rf.rename_rd] = rf.rename_tag;
            mdep = nd;
        end
    endtask

    task automatic tick(input string tag);
        check({tag, "_rs1_value"}, rf.rs1_value, exp_val(rf.rs1_idx));
        check({tag, "_rs1_tag"},   {27'd0, rf.rs1_tag}, exp_tag(rf.rs1_idx));
        check({tag, "_rs2_value"}, rf.rs2_value, exp_val(rf.rs2_idx));
        check({tag, "_rs2_tag"},   {27'd0, rf.rs2_tag}, exp_tag(rf.rs2_idx));
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    initial begin
        logic [4:0]  crd, cdep, rrd, rtag;
        logic [31:0] cres;

        rst = 1'b1;
        set_idle(5'd0, 5'd0);
        @(posedge clk);
        update_model();
        @(negedge clk);
        rst = 1'b0;

        set_idle(5'd5, 5'd0);
        check("reset_rs1_value", rf.rs1_value, 32'd0);
        check("reset_rs1_tag", {27'd0, rf.rs1_tag}, 32'd0);
        check("reset_rs2_value", rf.rs2_value, 32'd0);
        check("reset_rs2_tag", {27'd0, rf.rs2_tag}, 32'd0);
        tick("reset");

        set_in(1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 5'd0);
        check("rename_not_forwarded", {27'd0, rf.rs1_tag}, 32'd0);
        tick("ren5");
        set_idle(5'd5, 5'd0);
        check("x5_pending_tag", {27'd0, rf.rs1_tag}, 32'd3);
        tick("x5pend");
        set_in(1, 0, 1, 5'd5, 32'hDEADBEEF, 5'd3, 0, 0, 0, 5'd5, 5'd0);
        check("bypass_value", rf.rs1_value, 32'hDEADBEEF);
        check("bypass_tag", {27'd0, rf.rs1_tag}, 32'd0);
        tick("com5");
        set_idle(5'd5, 5'd0);
        check("x5_stored_value", rf.rs1_value, 32'hDEADBEEF);
        check("x5_stored_tag", {27'd0, rf.rs1_tag}, 32'd0);
        tick("x5done");

        set_in(1, 0, 0, 0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 5'd5);
        tick("ren7a");
        set_in(1, 0, 0, 0, 0, 0, 1, 5'd7, 5'd4, 5'd7, 5'd5);
        tick("ren7b");
        set_in(1, 0, 1, 5'd7, 32'd11, 5'd2, 0, 0, 0, 5'd7, 5'd5);
        check("old_commit_no_bypass", {27'd0, rf.rs1_tag}, 32'd4);
        tick("com7");
        set_idle(5'd7, 5'd5);
        check("x7_value", rf.rs1_value, 32'd11);
        check("x7_young_tag_kept", {27'd0, rf.rs1_tag}, 32'd4);
        tick("x7");

        set_in(1, 0, 0, 0, 0, 0, 1, 5'd9, 5'd6, 5'd9, 5'd7);
        tick("ren9");
        set_in(1, 0, 1, 5'd9, 32'd42, 5'd6, 1, 5'd9, 5'd8, 5'd9, 5'd7);
        tick("com_ren9");
        set_idle(5'd9, 5'd7);
        check("x9_value", rf.rs1_value, 32'd42);
        check("x9_rename_wins", {27'd0, rf.rs1_tag}, 32'd8);
        tick("x9");

        set_in(1, 0, 0, 0, 0, 0, 1, 5'd1, 5'd10, 5'd1, 5'd2);
        tick("ren1");
        set_in(1, 0, 0, 0, 0, 0, 1, 5'd2, 5'd11, 5'd1, 5'd2);
        tick("ren2");
        set_in(1, 0, 0, 0, 0, 0, 1, 5'd3, 5'd12, 5'd1, 5'd3);
        tick("ren3");
        set_in(1, 1, 1, 5'd1, 32'h100, 5'd10, 1, 5'd5, 5'd13, 5'd2, 5'd3);
        tick("flush");
        set_idle(5'd1, 5'd2);
        check("flush_x1_value", rf.rs1_value, 32'h100);
        check("flush_x1_tag", {27'd0, rf.rs1_tag}, 32'd0);
        check("flush_x2_tag", {27'd0, rf.rs2_tag}, 32'd0);
        tick("post_flush_a");
        set_idle(5'd3, 5'd5);
        check("flush_x3_tag", {27'd0, rf.rs1_tag}, 32'd0);
        check("flush_ignores_rename", {27'd0, rf.rs2_tag}, 32'd0);
        tick("post_flush_b");

        set_in(1, 0, 1, 5'd0, 32'd99, 5'd5, 1, 5'd0, 5'd5, 5'd0, 5'd0);
        tick("x0_write");
        set_idle(5'd0, 5'd4);
        check("x0_value", rf.rs1_value, 32'd0);
        check("x0_tag", {27'd0, rf.rs1_tag}, 32'd0);
        tick("x0");
        set_in(0, 0, 1, 5'd4, 32'd77, 5'd0, 1, 5'd4, 5'd9, 5'd4, 5'd4);
        tick("stall");
        set_idle(5'd4, 5'd4);
        check("stall_x4_value", rf.rs1_value, 32'd0);
        check("stall_x4_tag", {27'd0, rf.rs1_tag}, 32'd0);
        tick("post_stall");

        // Narrow index range keeps commit/rename/read collisions frequent.
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            crd  = 5'($urandom_range(0, 7));
            rrd  = 5'($urandom_range(0, 7));
            rtag = 5'($urandom_range(1, 31));
            cres = $urandom;
            cdep = ($urandom_range(0, 1) == 1) ? mdep[crd] : 5'($urandom_range(1, 31));
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 1) == 1, crd, cres, cdep,
                   $urandom_range(0, 2) != 0, rrd, rtag,
                   ($urandom_range(0, 1) == 1) ? crd : 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)));
            tick("rand");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
